// File: rtl/c17_bist_ctrl.sv
// BIST controller: drives a combinational CUT with LFSR patterns, compacts its
// responses into a MISR, and compares the signature against a golden value.
module c17_bist_ctrl #(
    parameter int                    N_IN      = 5,
    parameter int                    N_OUT     = 2,
    parameter int                    MISR_W    = 8,
    parameter logic [MISR_W-1:0]     MISR_POLY = 8'h1D,
    parameter int                    PATTERNS  = 31,
    parameter logic [N_IN-1:0]       SEED      = 5'b00001,
    parameter logic [MISR_W-1:0]     GOLDEN    = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   cut_in,
    input  logic [N_OUT-1:0]  cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam int CNT_W = $clog2(PATTERNS + 1);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [N_IN-1:0]  SEED_EFF = (SEED == '0) ? N_IN'(1) : SEED;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(PATTERNS - 1);

    typedef enum logic [1:0] {IDLE, APPLY, COMPARE, DONE} state_t;

    state_t            state;
    logic [N_IN-1:0]   lfsr;
    logic [N_IN-1:0]   lfsr_next;
    logic [CNT_W-1:0]  count;
    logic [MISR_W-1:0] cut_ext;
    logic [MISR_W-1:0] misr_next;

    always_comb begin
        cut_ext              = '0;
        cut_ext[N_OUT-1:0]   = cut_out;
        lfsr_next            = {lfsr[N_IN-2:0], lfsr[N_IN-1] ^ lfsr[1]};
        misr_next            = {signature[MISR_W-2:0], 1'b0}
                             ^ (signature[MISR_W-1] ? MISR_POLY : '0)
                             ^ cut_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= SEED_EFF;
            count     <= '0;
            signature <= '0;
            cut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else if (abort) begin
            // Signature is deliberately left alone so it can be inspected.
            state  <= IDLE;
            cut_in <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= APPLY;
                        lfsr      <= SEED_EFF;
                        count     <= '0;
                        signature <= '0;
                        cut_in    <= SEED_EFF;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                APPLY: begin
                    signature <= misr_next;
                    lfsr      <= lfsr_next;
                    count     <= count + CNT_W'(1);
                    if (count == LAST) begin
                        state  <= COMPARE;
                        cut_in <= '0;
                    end else begin
                        cut_in <= lfsr_next;
                    end
                end
                COMPARE: begin
                    pass  <= (signature == GOLDEN);
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    cut_in <= '0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench for c17_bist_ctrl: pattern sequence, pass/fail paths, abort,
// async reset, restart, and golden runs against a real c17 netlist.
module tb_c17_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] cut_in;
    logic [1:0] cut_out;
    logic       busy, done, pass;
    logic [7:0] signature;

    int   mode = 0;          // 0: tied zero, 1: forced pulse, 2: c17 netlist
    logic force_bit = 1'b0;
    int   checks = 0;
    int   errors = 0;

    c17_bist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cut_in(cut_in), .cut_out(cut_out), .busy(busy), .done(done),
        .pass(pass), .signature(signature)
    );

    always #5 clk = ~clk;

    // ISCAS c17: inputs N1,N2,N3,N6,N7 = x[0..4], outputs {N23,N22}
    function automatic logic [1:0] c17(input logic [4:0] x);
        logic n10, n11, n16, n19;
        n10 = ~(x[0] & x[2]);
        n11 = ~(x[2] & x[3]);
        n16 = ~(x[1] & n11);
        n19 = ~(n11 & x[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    always_comb cut_out = (mode == 2) ? c17(cut_in) : {1'b0, force_bit};

    function automatic logic [7:0] model_sig(input int m, input int n);
        logic [4:0] q;
        logic [7:0] s;
        logic [1:0] r;
        q = 5'd1;
        s = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (m == 2)                r = c17(q);
            else if (m == 1 && k == 9) r = 2'b01;
            else                       r = 2'b00;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {6'b0, r};
            q = {q[3:0], q[4] ^ q[1]};
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run and counts edges after the start edge until done (bounded).
    task automatic run(input int start_at, input int force_at,
                       output int edges, output logic [4:0] first_in);
        start = 1'b1;
        tick();
        start = 1'b0;
        first_in = cut_in;
        edges = 0;
        while (!done && edges < 100) begin
            if (edges == start_at) start = 1'b1;
            if (edges == force_at) force_bit = 1'b1;
            tick();
            start = 1'b0;
            force_bit = 1'b0;
            edges++;
        end
        $display("run: edges=%0d signature=%02h pass=%0b", edges, signature, pass);
    endtask

    initial begin
        logic [4:0] exp_seq [7];
        bit         seen [32];
        int         e;
        logic [4:0] first;
        logic [7:0] sig_c17;

        exp_seq = '{5'h01, 5'h02, 5'h05, 5'h0A, 5'h15, 5'h0B, 5'h17};
        foreach (seen[i]) seen[i] = 1'b0;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_sig", signature, 0);
        check("rst_cut_in", cut_in, 0);
        rst_n = 1'b1;
        tick();

        // Pattern sequence and pass path
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 31; k++) begin
            if (k < 7) check($sformatf("seq%0d", k), cut_in, exp_seq[k]);
            check($sformatf("distinct%0d", k), (cut_in != 0 && !seen[cut_in]), 1);
            seen[cut_in] = 1'b1;
            if (k == 0) check("apply_busy", busy, 1);
            tick();
        end
        check("cmp_cut_in", cut_in, 0);
        check("cmp_busy", busy, 1);
        check("cmp_done", done, 0);
        tick();
        check("pass_done", done, 1);
        check("pass_pass", pass, 1);
        check("pass_sig", signature, 8'h00);
        check("pass_busy", busy, 0);

        // Restart from DONE, with an ignored start during APPLY
        run(3, -1, e, first);
        check("restart_first", first, 5'h01);
        check("restart_edges", e, 32);
        check("restart_pass", pass, 1);

        // Fail path: a single forced response on the 10th APPLY cycle
        mode = 1;
        run(-1, 9, e, first);
        check("fail_edges", e, 32);
        check("fail_sig", signature, model_sig(1, 31));
        check("fail_sig_nonzero", signature != 8'h00, 1);
        check("fail_pass", pass, 0);

        // Mid-run abort on the 5th APPLY cycle
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_cut_in", cut_in, 0);
        check("abort_sig", signature, model_sig(2, 4));
        tick();
        check("abort_idle_busy", busy, 0);
        mode = 0;
        run(-1, -1, e, first);
        check("abort_rerun_edges", e, 32);
        check("abort_rerun_pass", pass, 1);
        check("abort_rerun_sig", signature, 8'h00);

        // Abort and start on the same edge: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_done", done, 0);
        check("abort_start_pass", pass, 0);
        check("abort_start_cut_in", cut_in, 0);

        // Back-to-back golden runs with the c17 netlist
        mode = 2;
        sig_c17 = model_sig(2, 31);
        run(-1, -1, e, first);
        check("c17_run1_edges", e, 32);
        check("c17_run1_sig", signature, sig_c17);
        check("c17_run1_pass", pass, (sig_c17 == 8'h00));
        run(-1, -1, e, first);
        check("c17_run2_edges", e, 32);
        check("c17_run2_sig", signature, sig_c17);

        // Asynchronous reset between edges during APPLY
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("pre_rst_sig", signature, model_sig(2, 6));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_pass", pass, 0);
        check("arst_sig", signature, 0);
        check("arst_cut_in", cut_in, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c17_bist_ctrl.md
# c17_bist_ctrl

Built-in self-test controller for the combinational benchmark netlists. It is the stimulus/response end of the netlist interface: it drives the circuit-under-test (CUT) primary inputs with pseudo-random LFSR patterns and compacts the CUT primary outputs into a MISR signature. After a fixed pattern count it compares the signature against a golden value and reports pass/fail. The CUT is purely combinational and sits between `cut_in` and `cut_out`.

## Interface
Parameters:
- `N_IN`, default 5: CUT input count and LFSR width. Feedback taps are fixed for 5.
- `N_OUT`, default 2: CUT output count. Must be ≤ `MISR_W`.
- `MISR_W`, default 8: signature width.
- `MISR_POLY`, default 8'h1D: MISR feedback mask (x^8+x^4+x^3+x^2+1).
- `PATTERNS`, default 31: patterns applied per run. Range 1..2^N_IN−1.
- `SEED`, default 5'b00001: LFSR seed. An all-zero value is replaced by 5'b00001.
- `GOLDEN`, default 8'h00: expected signature.

Ports:
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begin a run. Sampled only in IDLE and DONE.
- `abort`, input, 1: synchronous abort. Takes priority over every other event.
- `cut_in`, output, N_IN: CUT input pattern.
- `cut_out`, input, N_OUT: CUT response.
- `busy`, output, 1: high in APPLY and COMPARE.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: comparison result. Valid while `done` is high.
- `signature`, output, MISR_W: current MISR contents.

## Operation
- States: IDLE, APPLY, COMPARE, DONE.
- IDLE, or DONE, with `start`=1:
  - load the LFSR with `SEED`, clear the MISR to 0, clear the counter to 0.
  - clear `pass` and go to APPLY.
- APPLY, on each edge:
  - MISR absorbs `cut_out`: `misr <= {misr[W-2:0],0} ^ (misr[W-1] ? MISR_POLY : 0) ^ zero-extended cut_out`.
  - LFSR advances: `q <= {q[3:0], q[4]^q[1]}`. This is maximal length, period 31.
  - The counter increments. On the edge where the counter reaches `PATTERNS`−1, go to COMPARE. Exactly `PATTERNS` responses are absorbed.
- COMPARE: `pass <= (misr == GOLDEN)`, then go to DONE. The MISR is frozen.
- DONE: `done`=1, and `pass` and `signature` are held. `start` begins a new run directly.
- `cut_in`:
  - equals the LFSR value in APPLY.
  - is 0 in every other state.
- `abort`=1 in any state, on the next edge:
  - go to IDLE and clear `pass`.
  - `signature` keeps its last value.
  - the counter and LFSR contents are don't-care until the next `start`.
- `start` asserted in APPLY or COMPARE is ignored. It is not queued.
- Counter width is `$clog2(PATTERNS+1)`. The counter never wraps within a run.

## Timing
- Reset values (asynchronous assert, synchronous use after deassert):
  - state IDLE.
  - `busy`, `done`, `pass` = 0.
  - `signature` = 0.
  - `cut_in` = 0.
- Edge E0 samples `start` and enters APPLY. `cut_in`=SEED becomes visible after E0.
- The response to pattern k is sampled on edge E(k+1), k = 0..PATTERNS−1.
- COMPARE is entered after E(PATTERNS). `done`/`pass` become valid after E(PATTERNS+1). For the default parameters that is 32 edges after E0.
- `busy` is high from after E0 until after E(PATTERNS+1). `busy` and `done` are never high together.
- `abort` and `start` on the same edge: `abort` wins, and the block ends in IDLE.
- `PATTERNS`=1: one APPLY cycle, then COMPARE, then DONE.

## Test plan
- Pattern sequence: reset, pulse `start`, default `SEED`.
  - Required: `cut_in` reads 0x01, 0x02, 0x05, 0x0A, 0x15, 0x0B, 0x17 on successive APPLY cycles.
  - Required: 31 distinct nonzero values, no repeat, then `cut_in`=0 in COMPARE.
- Pass path: `cut_out` tied to 2'b00, `GOLDEN`=8'h00.
  - Required: `done`=1 exactly 32 edges after the `start` edge, `pass`=1, `signature`=8'h00, `busy`=0.
- Fail path: as the pass-path case, but force `cut_out`=2'b01 on the 10th APPLY cycle only.
  - Required: `signature` ≠ 8'h00 and `pass`=0 at `done`.
- Mid-run abort: pulse `abort` on the 5th APPLY cycle.
  - Required: IDLE next edge, `busy`=0, `done`=0, `pass`=0, `cut_in`=0, `signature` retained.
  - Then `start`: a full 32-edge run with the same results as the pass-path case.
- Async reset mid-run: drop `rst_n` between edges during APPLY.
  - Required: all outputs at reset values immediately, without waiting for a clock edge.
- Restart and ignored start: pulse `start` while in DONE.
  - Required: a new run begins with `cut_in`=0x01.
  - Required: `start` pulsed during APPLY has no effect on the cycle count.
- Back-to-back golden runs with a real c17 netlist: two runs give identical signatures.
